// File: rtl/door_lock_ctrl_if.sv
// Bus between the keypad code checker and the door-lock controller.
// The checker side (master) drives the verdicts and, with DOOR_ALARM_EN,
// the door sensor; the controller side (slave) drives the lock outputs.
interface door_lock_ctrl_if;
    logic       code_correct;
    logic       code_incorrect;
    logic       unlock;
    logic       locked_out;
    logic       checker_reset;
    logic [3:0] fail_count;
`ifdef DOOR_ALARM_EN
    logic       door_open;
    logic       alarm;

    modport master (
        output code_correct, code_incorrect, door_open,
        input  unlock, locked_out, checker_reset, fail_count, alarm
    );
    modport slave (
        input  code_correct, code_incorrect, door_open,
        output unlock, locked_out, checker_reset, fail_count, alarm
    );
`else
    modport master (
        output code_correct, code_incorrect,
        input  unlock, locked_out, checker_reset, fail_count
    );
    modport slave (
        input  code_correct, code_incorrect,
        output unlock, locked_out, checker_reset, fail_count
    );
`endif
endinterface

// File: rtl/door_lock_ctrl.sv
// Door-lock controller: timed unlock on a correct code, consecutive-failure
// counting with timed lockout, and a one-cycle checker re-arm after every
// verdict. Optional forced-entry alarm is built when DOOR_ALARM_EN is defined.
module door_lock_ctrl #(
    parameter int unsigned UNLOCK_CYCLES  = 50,
    parameter int unsigned LOCKOUT_CYCLES = 200,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    door_lock_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UNLOCKED = 2'd1,
        REARM    = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] UNLOCK_LOAD  = CNT_W'(UNLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCKOUT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]       FAIL_LIMIT   = 4'(MAX_FAILS);

    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [3:0]       fail_count;
    logic [3:0]       fail_next;

    assign fail_next = fail_count + 4'd1;

    // Main FSM: state, shared down-counter timer and failure counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= REARM;
            timer      <= '0;
            fail_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.code_correct) begin
                        state      <= UNLOCKED;
                        timer      <= UNLOCK_LOAD;
                        fail_count <= '0;
                    end else if (bus.code_incorrect) begin
                        fail_count <= fail_next;
                        if (fail_next >= FAIL_LIMIT) begin
                            state <= LOCKOUT;
                            timer <= LOCKOUT_LOAD;
                        end else begin
                            state <= REARM;
                        end
                    end
                end
                UNLOCKED: begin
                    if (timer == '0) state <= REARM;
                    else             timer <= timer - CNT_W'(1);
                end
                LOCKOUT: begin
                    if (timer == '0) begin
                        state      <= REARM;
                        fail_count <= '0;
                    end else begin
                        timer <= timer - CNT_W'(1);
                    end
                end
                REARM:   state <= IDLE;
                default: state <= REARM;
            endcase
        end
    end

    assign bus.unlock        = (state == UNLOCKED);
    assign bus.locked_out    = (state == LOCKOUT);
    assign bus.checker_reset = (state != IDLE);
    assign bus.fail_count    = fail_count;

`ifdef DOOR_ALARM_EN
    logic alarm_q;

    // Sticky forced-entry alarm; entry to UNLOCKED clears it and wins over a set.
    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else if (state == IDLE && bus.code_correct) begin
            alarm_q <= 1'b0;
        end else if (bus.door_open && state != UNLOCKED) begin
            alarm_q <= 1'b1;
        end
    end

    assign bus.alarm = alarm_q;
`endif

endmodule

// File: tb/tb_door_lock_ctrl.sv
// Randomized scoreboard bench for door_lock_ctrl. Alarm checks are compiled
// in when DOOR_ALARM_EN is defined.
module tb_door_lock_ctrl;

    localparam int unsigned UNLOCK_CYCLES  = 5;
    localparam int unsigned LOCKOUT_CYCLES = 8;
    localparam int unsigned MAX_FAILS      = 3;
    localparam int unsigned CNT_W          = 16;
    localparam int unsigned N_CYCLES       = 3000;

    typedef struct packed {
        logic       unlock;
        logic       locked_out;
        logic       checker_reset;
        logic [3:0] fail_count;
        logic       alarm;
    } exp_t;

    logic clk;
    logic reset;
    door_lock_ctrl_if bus();

    door_lock_ctrl #(
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .MAX_FAILS     (MAX_FAILS),
        .CNT_W         (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   armed    = 1'b0;

    function automatic exp_t mk(logic u, logic lo, logic cr, logic [3:0] fc);
        exp_t e;
        e.unlock        = u;
        e.locked_out    = lo;
        e.checker_reset = cr;
        e.fail_count    = fc;
        e.alarm         = 1'b0;
        return e;
    endfunction

    // Monitor: every cycle after the edge the DUT presents its outputs.
    exp_t mon_exp;
    exp_t mon_got;
    always @(posedge clk) begin
        #1;
        if (armed) begin
            n_checks++;
            mon_got = mk(bus.unlock, bus.locked_out, bus.checker_reset, bus.fail_count);
`ifdef DOOR_ALARM_EN
            mon_got.alarm = bus.alarm;
`endif
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow t=%0t got=%b expected an entry", $time, mon_got);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t got unlock=%b locked_out=%b checker_reset=%b fail_count=%0d alarm=%b required unlock=%b locked_out=%b checker_reset=%b fail_count=%0d alarm=%b",
                             $time, mon_got.unlock, mon_got.locked_out, mon_got.checker_reset,
                             mon_got.fail_count, mon_got.alarm, mon_exp.unlock, mon_exp.locked_out,
                             mon_exp.checker_reset, mon_exp.fail_count, mon_exp.alarm);
                end
            end
        end
    end

    // Stimulus + reference model: a schedule of predetermined per-edge
    // outputs; when it is empty the controller is listening to the checker.
    exp_t sched[$];
    int   fails;
    logic m_alarm;
    logic last_unlock;
    bit   post_reset;

    initial begin
        exp_t e;
        bit   do_reset, c, inc, door, listening;
        int   r;

        reset              = 1'b1;
        bus.code_correct   = 1'b0;
        bus.code_incorrect = 1'b0;
`ifdef DOOR_ALARM_EN
        bus.door_open      = 1'b0;
`endif
        fails       = 0;
        m_alarm     = 1'b0;
        last_unlock = 1'b0;
        post_reset  = 1'b0;

        for (int cyc = 0; cyc < int'(N_CYCLES); cyc++) begin
            @(negedge clk);
            do_reset = (cyc < 3) || ($urandom_range(0, 199) == 0);
            r    = int'($urandom_range(0, 99));
            c    = (r < 25) || (r >= 65 && r < 75);
            inc  = (r >= 25 && r < 75);
            door = ($urandom_range(0, 9) == 0);

            reset              = do_reset;
            bus.code_correct   = c;
            bus.code_incorrect = inc;
`ifdef DOOR_ALARM_EN
            bus.door_open      = door;
`endif

            if (do_reset) begin
                sched.delete();
                fails      = 0;
                m_alarm    = 1'b0;
                post_reset = 1'b1;
                e          = mk(1'b0, 1'b0, 1'b1, 4'd0);
            end else begin
                // First edge out of reset leaves the re-arm cycle for IDLE.
                if (post_reset) begin
                    post_reset = 1'b0;
                    sched.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0));
                end
                listening = (sched.size() == 0);
                if (listening) begin
                    if (c) begin
                        fails = 0;
                        repeat (UNLOCK_CYCLES) sched.push_back(mk(1'b1, 1'b0, 1'b1, 4'd0));
                        sched.push_back(mk(1'b0, 1'b0, 1'b1, 4'd0));
                        sched.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0));
                    end else if (inc) begin
                        fails++;
                        if (fails >= int'(MAX_FAILS)) begin
                            repeat (LOCKOUT_CYCLES) sched.push_back(mk(1'b0, 1'b1, 1'b1, 4'(fails)));
                            fails = 0;
                            sched.push_back(mk(1'b0, 1'b0, 1'b1, 4'd0));
                            sched.push_back(mk(1'b0, 1'b0, 1'b0, 4'd0));
                        end else begin
                            sched.push_back(mk(1'b0, 1'b0, 1'b1, 4'(fails)));
                            sched.push_back(mk(1'b0, 1'b0, 1'b0, 4'(fails)));
                        end
                    end else begin
                        sched.push_back(mk(1'b0, 1'b0, 1'b0, 4'(fails)));
                    end
                end
                e = sched.pop_front();
`ifdef DOOR_ALARM_EN
                if (listening && c)            m_alarm = 1'b0;
                else if (door && !last_unlock) m_alarm = 1'b1;
`endif
                e.alarm = m_alarm;
            end
            last_unlock = e.unlock;
            sb.push_back(e);
            armed = 1'b1;
        end

        @(negedge clk);
        armed = 1'b0;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain leftover=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t simulation did not complete", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/door_lock_ctrl.md
# door_lock_ctrl

Door-lock controller sitting directly downstream of the keypad code checker. It consumes the checker's level-held `correct`/`incorrect` verdicts, drives the lock solenoid for a timed unlock window, and counts consecutive failed attempts, with a timed lockout after too many failures. It also drives the checker's reset to re-arm it after every verdict, so the checker never needs an external reset between attempts.

## Interface
- `UNLOCK_CYCLES`, default 50: cycles `unlock` is held high per correct code; legal range 1 to 2^CNT_W.
- `LOCKOUT_CYCLES`, default 200: cycles `locked_out` is held high; legal range 1 to 2^CNT_W.
- `MAX_FAILS`, default 3: consecutive failures that trigger lockout; legal range 1 to 15.
- `CNT_W`, default 16: width of the shared down-counter timer.
- `clk`, input, 1: clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `code_correct`, input, 1: checker "correct" verdict; a level, held until the checker is reset.
- `code_incorrect`, input, 1: checker "incorrect" verdict; a level, held until the checker is reset.
- `unlock`, output, 1: solenoid drive; high means the door is unlocked.
- `locked_out`, output, 1: lockout indicator.
- `checker_reset`, output, 1: synchronous reset to the code checker.
- `fail_count`, output, 4: consecutive failures since the last success or lockout.
- `door_open`, input, 1: door-open sensor. Present only with `DOOR_ALARM_EN`.
- `alarm`, output, 1: forced-entry alarm. Present only with `DOOR_ALARM_EN`.

## Operation
- States:
  - IDLE: listening to the checker.
  - UNLOCKED: door unlocked.
  - REARM: one-cycle checker reset.
  - LOCKOUT: keypad disabled.
- Output decode:
  - `unlock` = (state == UNLOCKED).
  - `locked_out` = (state == LOCKOUT).
  - `checker_reset` = (state != IDLE), so the checker is held reset whenever this block is not listening.
- IDLE transitions:
  - `code_correct`=1: go to UNLOCKED, load timer with UNLOCK_CYCLES-1, clear `fail_count` to 0. If `code_incorrect` is also 1 in the same cycle, `code_correct` wins.
  - Else `code_incorrect`=1: `fail_count`+1. If the new count ≥ MAX_FAILS, go to LOCKOUT and load timer with LOCKOUT_CYCLES-1. Otherwise go to REARM.
  - Else: stay in IDLE.
- UNLOCKED: timer decrements each cycle. At timer==0, go to REARM. Checker inputs are ignored.
- LOCKOUT: timer decrements each cycle. At timer==0, clear `fail_count` and go to REARM. Checker inputs are ignored.
- REARM: always go to IDLE next cycle.
- `fail_count` is never incremented outside IDLE, so it never exceeds MAX_FAILS.
- Timer arithmetic is unsigned CNT_W bits. It is loaded only on state entry and never wraps, because it is not decremented below 0.
- Reset mid-operation: abandons any unlock window or lockout immediately.

## Timing
- Reset values:
  - State is REARM and timer is 0.
  - `unlock`=0, `locked_out`=0, `checker_reset`=1, `fail_count`=0, `alarm`=0.
  - The first cycle after reset release is REARM, so the checker is reset at least twice.
- Correct verdict sampled high in IDLE at edge N:
  - `unlock` is high for exactly UNLOCK_CYCLES cycles, starting at edge N.
  - REARM follows for 1 cycle, then IDLE.
- Non-locking failure: IDLE, then REARM (1 cycle), then IDLE, a 2-cycle round trip. The checker's held verdict is cleared by the REARM edge, so no double counting occurs.
- Lockout: `locked_out` is high for exactly LOCKOUT_CYCLES cycles, then REARM, then IDLE.
- Verdict-to-output latency is 1 clock. All outputs are decoded from registered state, with no combinational input-to-output path.

## Configuration
- `DOOR_ALARM_EN` defined:
  - Adds the `door_open` and `alarm` ports.
  - `alarm` is sticky. It sets on any cycle where `door_open`=1 and state != UNLOCKED.
  - It clears on `reset` or on entry to UNLOCKED. If set and cleared in the same cycle, clear wins.
  - `alarm` does not affect state transitions.
- `DOOR_ALARM_EN` undefined: neither port exists, and no alarm logic is built.

## Test plan
- Reset, then `code_correct` pulse with UNLOCK_CYCLES=5 → `unlock` high exactly 5 cycles; `checker_reset` low only in IDLE; `fail_count`=0.
- Two `code_incorrect` verdicts with MAX_FAILS=3 → `fail_count` reads 1 then 2; each followed by one REARM cycle; no lockout.
- Third `code_incorrect` with LOCKOUT_CYCLES=8 → `locked_out` high 8 cycles; `code_correct` during lockout is ignored; `fail_count`=0 after exit.
- `code_correct` and `code_incorrect` both high in IDLE → unlock is taken; `fail_count` is unchanged except cleared to 0.
- `reset` asserted mid-UNLOCKED and mid-LOCKOUT → next cycle `unlock`=0, `locked_out`=0, `checker_reset`=1, `fail_count`=0.
- `DOOR_ALARM_EN`: `door_open`=1 in IDLE → `alarm`=1 and stays 1 after the door closes; a subsequent correct code clears it on UNLOCKED entry.
